// File: rtl/uart_pkg.sv
// Shared definitions for the UART stream bridge: register map, STATUS bit
// positions and the sequencing FSM encoding.
package uart_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'h0;
    localparam logic [2:0] ADDR_STATUS = 3'h1;

    localparam int STAT_TX_BUSY = 0;
    localparam int STAT_RX_FULL = 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        STAT_REQ = 3'd1,
        STAT_CAP = 3'd2,
        RD_REQ   = 3'd3,
        RD_CAP   = 3'd4,
        WR_DATA  = 3'd5,
        GUARD    = 3'd6
    } bridge_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; push and pop may coincide in any
// state, and the read side is never a fall-through of the write side.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (level == '0);
    assign full     = (level == LW'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_stream_bridge.sv
// Bridges valid/ready byte streams to a polled UART register interface.
// Define UART_BRIDGE_STATS_EN to add the tx_count/rx_count byte counters.
//
// state    | meaning
// IDLE     | decide whether any TX or RX work may be possible
// STAT_REQ | STATUS read strobe on the bus
// STAT_CAP | STATUS returned; choose RX read, TX write or back to IDLE
// RD_REQ   | DATA read strobe on the bus
// RD_CAP   | DATA returned; push into RX FIFO
// WR_DATA  | DATA write strobe with TX FIFO head; pop TX FIFO
// GUARD    | one quiet cycle so the UART busy flag settles
module uart_stream_bridge
    import uart_pkg::*;
#(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    s_tx_data,
    input  logic                          s_tx_valid,
    output logic                          s_tx_ready,
    output logic [7:0]                    m_rx_data,
    output logic                          m_rx_valid,
    input  logic                          m_rx_ready,
    output logic [2:0]                    uart_addr,
    output logic                          uart_write_en,
    output logic                          uart_read_en,
    output logic [7:0]                    uart_write_data,
    input  logic [7:0]                    uart_read_data,
    output logic [$clog2(TX_DEPTH+1)-1:0] tx_level,
    output logic [$clog2(RX_DEPTH+1)-1:0] rx_level
`ifdef UART_BRIDGE_STATS_EN
    ,
    output logic [15:0]                   tx_count,
    output logic [15:0]                   rx_count
`endif
);

    bridge_state_t state;

    logic       tx_full;
    logic       tx_empty;
    logic       tx_push;
    logic       tx_pop;
    logic [7:0] tx_head;
    logic       rx_full;
    logic       rx_empty;
    logic       rx_push;
    logic       rx_pop;

    assign s_tx_ready = !tx_full;
    assign tx_push    = s_tx_valid && s_tx_ready;
    assign tx_pop     = (state == WR_DATA);
    assign m_rx_valid = !rx_empty;
    assign rx_pop     = m_rx_valid && m_rx_ready;
    assign rx_push    = (state == RD_CAP);

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tx_push),
        .push_data (s_tx_data),
        .pop       (tx_pop),
        .pop_data  (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .level     (tx_level)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rx_push),
        .push_data (uart_read_data),
        .pop       (rx_pop),
        .pop_data  (m_rx_data),
        .full      (rx_full),
        .empty     (rx_empty),
        .level     (rx_level)
    );

    // Strobes are registered and set on the transition into their state, so
    // each one is high for exactly the cycle the FSM spends in that state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            uart_addr       <= '0;
            uart_write_en   <= 1'b0;
            uart_read_en    <= 1'b0;
            uart_write_data <= '0;
        end else begin
            uart_write_en <= 1'b0;
            uart_read_en  <= 1'b0;
            case (state)
                IDLE: begin
                    if (!tx_empty || !rx_full) begin
                        state        <= STAT_REQ;
                        uart_addr    <= ADDR_STATUS;
                        uart_read_en <= 1'b1;
                    end
                end
                STAT_REQ: state <= STAT_CAP;
                STAT_CAP: begin
                    if (uart_read_data[STAT_RX_FULL] && !rx_full) begin
                        state        <= RD_REQ;
                        uart_addr    <= ADDR_DATA;
                        uart_read_en <= 1'b1;
                    end else if (!uart_read_data[STAT_TX_BUSY] && !tx_empty) begin
                        state           <= WR_DATA;
                        uart_addr       <= ADDR_DATA;
                        uart_write_data <= tx_head;
                        uart_write_en   <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                RD_REQ:  state <= RD_CAP;
                RD_CAP:  state <= IDLE;
                WR_DATA: state <= GUARD;
                GUARD:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UART_BRIDGE_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_count <= '0;
            rx_count <= '0;
        end else begin
            if (uart_write_en) begin
                tx_count <= tx_count + 16'd1;
            end
            if (rx_push) begin
                rx_count <= rx_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_stream_bridge.sv
// Directed bench for uart_stream_bridge with a behavioural UART register model
// that can hold TX busy, inject RX bytes, stream RX bytes or loop TX back to RX.
module tb_uart_stream_bridge;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] s_tx_data = 8'h00;
    logic       s_tx_valid = 1'b0;
    logic       s_tx_ready;
    logic [7:0] m_rx_data;
    logic       m_rx_valid;
    logic       m_rx_ready = 1'b0;
    logic [2:0] uart_addr;
    logic       uart_write_en;
    logic       uart_read_en;
    logic [7:0] uart_write_data;
    logic [7:0] uart_read_data = 8'h00;
    logic [4:0] tx_level;
    logic [4:0] rx_level;
`ifdef UART_BRIDGE_STATS_EN
    logic [15:0] tx_count;
    logic [15:0] rx_count;
`endif

    uart_stream_bridge #(.TX_DEPTH(16), .RX_DEPTH(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .s_tx_data       (s_tx_data),
        .s_tx_valid      (s_tx_valid),
        .s_tx_ready      (s_tx_ready),
        .m_rx_data       (m_rx_data),
        .m_rx_valid      (m_rx_valid),
        .m_rx_ready      (m_rx_ready),
        .uart_addr       (uart_addr),
        .uart_write_en   (uart_write_en),
        .uart_read_en    (uart_read_en),
        .uart_write_data (uart_write_data),
        .uart_read_data  (uart_read_data),
        .tx_level        (tx_level),
        .rx_level        (rx_level)
`ifdef UART_BRIDGE_STATS_EN
        ,
        .tx_count        (tx_count),
        .rx_count        (rx_count)
`endif
    );

    always #5 clk = ~clk;

    // UART model controls, written only by the stimulus process
    logic       tx_busy = 1'b0;
    logic       rx_auto = 1'b0;
    logic       loopback = 1'b0;
    logic [7:0] inj_data = 8'h00;
    int         inj_cnt = 0;

    // UART model state, written only by the model process
    int         inj_taken = 0;
    logic       lb_pending = 1'b0;
    logic [7:0] lb_byte = 8'h00;
    logic [7:0] auto_byte = 8'h80;
    logic       last_rd_status = 1'b0;
    int         data_reads = 0;
    int         reads_during_reset = 0;
    int         both_err = 0;
    logic [7:0] wr_data_q [$];
    logic [2:0] wr_addr_q [$];
    logic       wr_pre_q  [$];

    logic       rx_full_w;
    logic [7:0] rx_byte_w;
    assign rx_full_w = rx_auto || lb_pending || (inj_taken != inj_cnt);
    assign rx_byte_w = rx_auto ? auto_byte : (lb_pending ? lb_byte : inj_data);

    always @(posedge clk) begin
        if (!rst_n && (uart_read_en || uart_write_en)) begin
            reads_during_reset <= reads_during_reset + 1;
        end
        if (uart_read_en) begin
            if (uart_addr == 3'h1) begin
                uart_read_data <= {6'b0, rx_full_w, tx_busy};
                last_rd_status <= 1'b1;
            end else begin
                uart_read_data <= rx_byte_w;
                last_rd_status <= 1'b0;
                data_reads     <= data_reads + 1;
                if (rx_auto) auto_byte <= auto_byte + 8'd1;
                else if (lb_pending) lb_pending <= 1'b0;
                else if (inj_taken != inj_cnt) inj_taken <= inj_taken + 1;
            end
        end
        if (uart_write_en) begin
            wr_data_q.push_back(uart_write_data);
            wr_addr_q.push_back(uart_addr);
            wr_pre_q.push_back(last_rd_status);
            if (loopback) begin
                lb_pending <= 1'b1;
                lb_byte    <= uart_write_data;
            end
        end
        if (uart_write_en && uart_read_en) both_err <= both_err + 1;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] d);
        @(negedge clk);
        s_tx_data  = d;
        s_tx_valid = 1'b1;
        @(negedge clk);
        s_tx_valid = 1'b0;
    endtask

    task automatic wait_tx_drain(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (tx_level == 5'd0 && dut.state == 3'd0) break;
        end
    endtask

    int base;
    int rd_base;
    logic got_valid;

    initial begin
        // reset
        repeat (3) @(negedge clk);
        chk_eq("rst_s_tx_ready", 32'(s_tx_ready), 32'd1);
        chk_eq("rst_m_rx_valid", 32'(m_rx_valid), 32'd0);
        chk_eq("rst_m_rx_data", 32'(m_rx_data), 32'h00);
        chk_eq("rst_uart_addr", 32'(uart_addr), 32'd0);
        chk_eq("rst_strobes", 32'({uart_write_en, uart_read_en}), 32'd0);
        chk_eq("rst_wdata", 32'(uart_write_data), 32'h00);
        chk_eq("rst_levels", 32'({tx_level, rx_level}), 32'd0);
        chk_eq("rst_no_strobe", 32'(reads_during_reset), 32'd0);
        rst_n = 1'b1;

        // single TX, UART idle
        base = wr_data_q.size();
        push_byte(8'h55);
        wait_tx_drain(50);
        repeat (5) @(negedge clk);
        chk_eq("single_wr_cnt", 32'(wr_data_q.size() - base), 32'd1);
        if (wr_data_q.size() > base) begin
            chk_eq("single_wr_data", 32'(wr_data_q[base]), 32'h55);
            chk_eq("single_wr_addr", 32'(wr_addr_q[base]), 32'd0);
        end
        chk_eq("single_tx_level", 32'(tx_level), 32'd0);

        // TX busy throttle
        tx_busy = 1'b1;
        base = wr_data_q.size();
        push_byte(8'hAA);
        push_byte(8'h55);
        repeat (200) @(negedge clk);
        chk_eq("busy_no_writes", 32'(wr_data_q.size() - base), 32'd0);
        chk_eq("busy_tx_level", 32'(tx_level), 32'd2);
        tx_busy = 1'b0;
        wait_tx_drain(60);
        chk_eq("busy_wr_cnt", 32'(wr_data_q.size() - base), 32'd2);
        if (wr_data_q.size() >= base + 2) begin
            chk_eq("busy_wr0", 32'(wr_data_q[base]), 32'hAA);
            chk_eq("busy_wr1", 32'(wr_data_q[base+1]), 32'h55);
            chk_eq("busy_pre_stat0", 32'(wr_pre_q[base]), 32'd1);
            chk_eq("busy_pre_stat1", 32'(wr_pre_q[base+1]), 32'd1);
        end

        // TX full / backpressure
        tx_busy = 1'b1;
        base = wr_data_q.size();
        for (int i = 0; i < 16; i++) push_byte(8'h10 + 8'(i));
        chk_eq("full_s_tx_ready", 32'(s_tx_ready), 32'd0);
        chk_eq("full_tx_level", 32'(tx_level), 32'd16);
        push_byte(8'hEE);
        chk_eq("full_17th_ignored", 32'(tx_level), 32'd16);
        tx_busy = 1'b0;
        wait_tx_drain(300);
        chk_eq("full_wr_cnt", 32'(wr_data_q.size() - base), 32'd16);
        if (wr_data_q.size() >= base + 16) begin
            for (int i = 0; i < 16; i++) begin
                chk_eq($sformatf("full_wr%0d", i), 32'(wr_data_q[base+i]), 32'h10 + 32'(i));
            end
        end
        chk_eq("full_ready_back", 32'(s_tx_ready), 32'd1);

        // RX path
        m_rx_ready = 1'b1;
        rd_base = data_reads;
        @(negedge clk);
        inj_data = 8'h33;
        inj_cnt  = inj_cnt + 1;
        got_valid = 1'b0;
        for (int i = 0; i < 14 && !got_valid; i++) begin
            @(negedge clk);
            if (m_rx_valid) begin
                got_valid = 1'b1;
                chk_eq("rx_data", 32'(m_rx_data), 32'h33);
            end
        end
        chk_eq("rx_valid_seen", 32'(got_valid), 32'd1);
        repeat (10) @(negedge clk);
        chk_eq("rx_level_empty", 32'(rx_level), 32'd0);
        chk_eq("rx_one_read", 32'(data_reads - rd_base), 32'd1);

        // RX full / backpressure
        m_rx_ready = 1'b0;
        rd_base = data_reads;
        rx_auto = 1'b1;
        repeat (300) @(negedge clk);
        chk_eq("rxfull_level", 32'(rx_level), 32'd16);
        chk_eq("rxfull_reads", 32'(data_reads - rd_base), 32'd16);
        chk_eq("rxfull_head", 32'(m_rx_data), 32'h80);
        repeat (100) @(negedge clk);
        chk_eq("rxfull_no_more_reads", 32'(data_reads - rd_base), 32'd16);
        chk_eq("rxfull_head_stable", 32'({m_rx_valid, m_rx_data}), 32'h180);
        rx_auto = 1'b0;
        repeat (5) @(negedge clk);
        m_rx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk_eq($sformatf("rxpop%0d", i), 32'({m_rx_valid, m_rx_data}), 32'h180 + 32'(i));
            @(negedge clk);
        end
        chk_eq("rxpop_drained", 32'({m_rx_valid, rx_level}), 32'd0);

        // loopback
        loopback = 1'b1;
        push_byte(8'h5A);
        got_valid = 1'b0;
        for (int i = 0; i < 60 && !got_valid; i++) begin
            @(negedge clk);
            if (m_rx_valid) begin
                got_valid = 1'b1;
                chk_eq("loop_data", 32'(m_rx_data), 32'h5A);
            end
        end
        chk_eq("loop_valid_seen", 32'(got_valid), 32'd1);
        loopback = 1'b0;
        repeat (5) @(negedge clk);

`ifdef UART_BRIDGE_STATS_EN
        chk_eq("stat_tx_count", 32'(tx_count), 32'd20);
        chk_eq("stat_rx_count", 32'(rx_count), 32'd18);
`endif
        chk_eq("strobe_exclusive", 32'(both_err), 32'd0);

        // mid-operation reset drops the strobe pipeline and the FIFOs
        tx_busy = 1'b1;
        push_byte(8'h77);
        rst_n = 1'b0;
        @(negedge clk);
        chk_eq("rst2_strobes", 32'({uart_write_en, uart_read_en}), 32'd0);
        chk_eq("rst2_tx_level", 32'(tx_level), 32'd0);
        rst_n = 1'b1;
        tx_busy = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
